// File: rtl/pseudo_spi_recv_intf.sv
// Pseudo-SPI receiver: deserialises LSB-first bytes clocked by SCLK1 and
// writes each completed byte into an SRAM at consecutive addresses starting
// one above ADDR_BGN. SCLK1/SCLK2/SPI_SI are already synchronous to CLK.
//
// state   | meaning
// --------+------------------------------------------------------------
// RX_IDLE | waiting for BGN; address/bit/byte counters preloaded
// RX_SHFT | shifting in bits on each SCLK1 rise
// RX_WRIT | one-cycle SRAM write of the assembled byte
// RX_LOOP | advance byte/address counters, decide done or next byte
// RX_DONE | transfer complete, spi_is_done held until BGN drops
module pseudo_spi_recv_intf #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SCLK1,
  input  logic                         SCLK2,
  input  logic                         SPI_SI,
  output logic                         CEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         D_WE,
  output logic                         spi_is_done,
  output logic                         ERR
);

  // Bit counter must be able to hold MEMORY_DATA_WIDTH itself, since it
  // reaches that value on the last rise and is only cleared in RX_LOOP.
  localparam int BIT_CNT_W = $clog2(MEMORY_DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(MEMORY_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0,
    RX_SHFT = 3'd1,
    RX_WRIT = 3'd2,
    RX_LOOP = 3'd3,
    RX_DONE = 3'd4
  } rx_state_t;

  rx_state_t state;
  rx_state_t next_state;

  logic                         sclk1_q;
  logic                         sclk1_rise;
  logic [MEMORY_DATA_WIDTH-1:0] shreg;
  logic [MEMORY_DATA_WIDTH-1:0] shreg_next;
  logic [BIT_CNT_W-1:0]         bit_cnt;
  logic [RESERVED_DATA_LEN-1:0] byte_cnt;
  logic [RESERVED_DATA_LEN-1:0] byte_cnt_inc;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_cnt;
  logic [MEMORY_ADDR_WIDTH-1:0] a_q;
  logic [MEMORY_DATA_WIDTH-1:0] po_q;
  logic                         err_q;
  logic                         shft_rise;
  logic                         byte_done;
  logic                         last_byte;

  assign sclk1_rise   = SCLK1 & ~sclk1_q;
  assign shft_rise    = (state == RX_SHFT) && sclk1_rise;
  assign byte_done    = shft_rise && (bit_cnt == LAST_BIT);
  assign shreg_next   = {SPI_SI, shreg[MEMORY_DATA_WIDTH-1:1]};
  assign byte_cnt_inc = byte_cnt + RESERVED_DATA_LEN'(1);
  assign last_byte    = (byte_cnt_inc == DATA_LEN);

  // Previous SCLK1 sample for registered rise detection.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sclk1_q <= 1'b0;
    end else begin
      sclk1_q <= SCLK1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= RX_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; dropping BGN anywhere outside idle aborts to idle.
  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE: begin
        if (BGN) begin
          if (DATA_LEN == '0) begin
            next_state = RX_DONE;
          end else begin
            next_state = RX_SHFT;
          end
        end
      end
      RX_SHFT: begin
        if (!BGN) begin
          next_state = RX_IDLE;
        end else if (byte_done) begin
          next_state = RX_WRIT;
        end
      end
      RX_WRIT: begin
        if (!BGN) begin
          next_state = RX_IDLE;
        end else begin
          next_state = RX_LOOP;
        end
      end
      RX_LOOP: begin
        if (!BGN) begin
          next_state = RX_IDLE;
        end else if (last_byte) begin
          next_state = RX_DONE;
        end else begin
          next_state = RX_SHFT;
        end
      end
      RX_DONE: begin
        if (!BGN) begin
          next_state = RX_IDLE;
        end
      end
      default: next_state = RX_IDLE;
    endcase
  end

  // Counters, shift register and the registered SRAM address/data.
  // PO and A are captured on the last rise so they are stable for the
  // whole write cycle and hold afterwards.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      addr_cnt <= '0;
      a_q      <= '0;
      po_q     <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          addr_cnt <= ADDR_BGN + MEMORY_ADDR_WIDTH'(1);
          bit_cnt  <= '0;
          byte_cnt <= '0;
          shreg    <= '0;
        end
        RX_SHFT: begin
          if (BGN && shft_rise) begin
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (byte_done) begin
              po_q <= shreg_next;
              a_q  <= addr_cnt;
            end
          end
        end
        RX_LOOP: begin
          byte_cnt <= byte_cnt_inc;
          addr_cnt <= addr_cnt + MEMORY_ADDR_WIDTH'(1);
          bit_cnt  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky overlap fault; only a quiescent idle (BGN low) clears it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (SCLK1 && SCLK2) begin
      err_q <= 1'b1;
    end else if ((state == RX_IDLE) && !BGN) begin
      err_q <= 1'b0;
    end
  end

  assign CEN         = (state != RX_WRIT);
  assign D_WE        = (state == RX_WRIT);
  assign A           = a_q;
  assign PO          = po_q;
  assign spi_is_done = (state == RX_DONE);
  assign ERR         = err_q;

endmodule

// File: tb/tb_pseudo_spi_recv_intf.sv
// Bench for pseudo_spi_recv_intf: a transaction-level model (queue of
// expected SRAM writes derived from base address and byte list) checked
// every cycle, plus literal checks on the captured write log.
module tb_pseudo_spi_recv_intf;

  logic       CLK;
  logic       rst_n;
  logic       BGN;
  logic [8:0] ADDR_BGN;
  logic [7:0] DATA_LEN;
  logic       SCLK1;
  logic       SCLK2;
  logic       SPI_SI;
  logic       CEN;
  logic [8:0] A;
  logic [7:0] PO;
  logic       D_WE;
  logic       spi_is_done;
  logic       ERR;

  int n_chk  = 0;
  int n_fail = 0;

  logic [16:0] exp_q[$];
  logic [16:0] wr_log[$];
  logic [8:0]  last_a = '0;
  logic        err_exp = 1'b0;
  logic        err_valid = 1'b1;
  logic [7:0]  tx[0:15];

  pseudo_spi_recv_intf #(
    .MEMORY_DATA_WIDTH(8),
    .MEMORY_ADDR_WIDTH(9),
    .RESERVED_DATA_LEN(8)
  ) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .BGN(BGN),
    .ADDR_BGN(ADDR_BGN),
    .DATA_LEN(DATA_LEN),
    .SCLK1(SCLK1),
    .SCLK2(SCLK2),
    .SPI_SI(SPI_SI),
    .CEN(CEN),
    .A(A),
    .PO(PO),
    .D_WE(D_WE),
    .spi_is_done(spi_is_done),
    .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected writes: byte i lands at (base + 1 + i) mod 512.
  task automatic push_writes(input logic [8:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [8:0] a;
      a = 9'((int'(base) + 1 + i) % 512);
      exp_q.push_back({a, tx[i]});
    end
  endtask

  task automatic send_bit(input logic b, input logic ovl);
    SPI_SI = b;
    SCLK1  = 1'b1;
    if (ovl) begin
      err_valid = 1'b0;
      SCLK2     = 1'b1;
    end
    tick();
    if (ovl) begin
      SCLK2     = 1'b0;
      err_exp   = 1'b1;
      err_valid = 1'b1;
    end
    tick();
    SCLK1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int ovl_bit);
    for (int i = 0; i < 8; i++) send_bit(b[i], i == ovl_bit);
  endtask

  task automatic start(input logic [8:0] base, input logic [7:0] len);
    ADDR_BGN = base;
    DATA_LEN = len;
    SCLK1    = 1'b0;
    BGN      = 1'b1;
    repeat (2) tick();
  endtask

  task automatic finish_xfer();
    BGN       = 1'b0;
    err_valid = 1'b0;
    repeat (2) tick();
    err_exp   = 1'b0;
    err_valid = 1'b1;
    tick();
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge CLK);
      if (spi_is_done === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: spi_is_done not seen within %0d cycles", name, max_cyc);
    end
    tick();
  endtask

  // Per-cycle compare against the write-queue model.
  always @(negedge CLK) begin
    if (!rst_n) begin
      chk("rst_cen", 32'(CEN), 32'd1);
      chk("rst_dwe", 32'(D_WE), 32'd0);
      chk("rst_a", 32'(A), 32'd0);
      chk("rst_po", 32'(PO), 32'd0);
      chk("rst_done", 32'(spi_is_done), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      last_a = '0;
    end else begin
      if (CEN === 1'b0) begin
        chk("write_dwe", 32'(D_WE), 32'd1);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got A=%0h PO=%0h expected no write (t=%0t)", A, PO, $time);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("write_addr", 32'(A), 32'(e[16:8]));
          chk("write_data", 32'(PO), 32'(e[7:0]));
        end
        wr_log.push_back({A, PO});
        last_a = A;
      end else begin
        chk("idle_dwe", 32'(D_WE), 32'd0);
        chk("idle_a_hold", 32'(A), 32'(last_a));
      end
      if (exp_q.size() != 0) chk("done_early", 32'(spi_is_done), 32'd0);
      if (err_valid) chk("err_flag", 32'(ERR), 32'(err_exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx0;
    int idx1;
    rst_n    = 1'b0;
    BGN      = 1'b0;
    ADDR_BGN = '0;
    DATA_LEN = '0;
    SCLK1    = 1'b0;
    SCLK2    = 1'b0;
    SPI_SI   = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_cen", 32'(CEN), 32'd1);
    chk("post_rst_a", 32'(A), 32'd0);
    chk("post_rst_po", 32'(PO), 32'd0);
    chk("post_rst_done", 32'(spi_is_done), 32'd0);

    // Fourteen bytes from base 1FF: addresses wrap to start at 0.
    tx[0] = 8'hAB; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h3C;
    tx[4] = 8'h00; tx[5] = 8'h05; tx[6] = 8'h3D; tx[7] = 8'h9E;
    tx[8] = 8'hC3; tx[9] = 8'hD7; tx[10] = 8'h58; tx[11] = 8'h7A;
    tx[12] = 8'h01; tx[13] = 8'hC2;
    idx0 = wr_log.size();
    push_writes(9'h1FF, 14);
    start(9'h1FF, 8'd14);
    for (int i = 0; i < 14; i++) send_byte(tx[i], -1);
    wait_done("long_done", 4);
    repeat (3) tick();
    chk("long_done_held", 32'(spi_is_done), 32'd1);
    chk("long_count", 32'(wr_log.size() - idx0), 32'd14);
    chk("long_first", 32'(wr_log[idx0]), 32'({9'h000, 8'hAB}));
    chk("long_last", 32'(wr_log[idx0 + 13]), 32'({9'h00D, 8'hC2}));
    finish_xfer();
    chk("long_done_cleared", 32'(spi_is_done), 32'd0);

    // Zero length: straight to done, no write.
    idx0 = wr_log.size();
    ADDR_BGN = 9'h055;
    DATA_LEN = 8'd0;
    BGN      = 1'b1;
    wait_done("zero_len_done", 2);
    repeat (2) tick();
    chk("zero_len_nowrite", 32'(wr_log.size() - idx0), 32'd0);
    finish_xfer();

    // Address wrap 1FF -> 000 -> 001.
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    idx0 = wr_log.size();
    push_writes(9'h1FE, 3);
    start(9'h1FE, 8'd3);
    for (int i = 0; i < 3; i++) send_byte(tx[i], -1);
    wait_done("wrap_done", 4);
    chk("wrap_w0", 32'(wr_log[idx0]), 32'({9'h1FF, 8'h11}));
    chk("wrap_w1", 32'(wr_log[idx0 + 1]), 32'({9'h000, 8'h22}));
    chk("wrap_w2", 32'(wr_log[idx0 + 2]), 32'({9'h001, 8'h33}));
    finish_xfer();

    // Abort after 5 bits of byte 2, then restart from the same base.
    tx[0] = 8'h5A;
    idx0 = wr_log.size();
    push_writes(9'h010, 1);
    start(9'h010, 8'd3);
    send_byte(8'h5A, -1);
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    finish_xfer();
    chk("abort_count", 32'(wr_log.size() - idx0), 32'd1);
    chk("abort_done", 32'(spi_is_done), 32'd0);
    tx[0] = 8'h3C; tx[1] = 8'h96; tx[2] = 8'h0F;
    idx1 = wr_log.size();
    push_writes(9'h010, 3);
    start(9'h010, 8'd3);
    for (int i = 0; i < 3; i++) send_byte(tx[i], -1);
    wait_done("restart_done", 4);
    chk("restart_first", 32'(wr_log[idx1]), 32'({9'h011, 8'h3C}));
    finish_xfer();

    // SCLK1/SCLK2 overlap: ERR sticks, data still written.
    tx[0] = 8'hE7; tx[1] = 8'h18;
    idx0 = wr_log.size();
    push_writes(9'h100, 2);
    start(9'h100, 8'd2);
    send_byte(tx[0], 3);
    send_byte(tx[1], -1);
    wait_done("ovl_done", 4);
    chk("ovl_err_held", 32'(ERR), 32'd1);
    chk("ovl_count", 32'(wr_log.size() - idx0), 32'd2);
    chk("ovl_w1", 32'(wr_log[idx0 + 1]), 32'({9'h102, 8'h18}));
    finish_xfer();
    chk("ovl_err_cleared", 32'(ERR), 32'd0);

    // Reset in the cycle after the 8th rise: write must not happen.
    idx0 = wr_log.size();
    start(9'h0AA, 8'd1);
    for (int i = 0; i < 7; i++) send_bit(1'(8'h81 >> i), 1'b0);
    SPI_SI = 1'b1;
    SCLK1  = 1'b1;
    tick();
    rst_n   = 1'b0;
    BGN     = 1'b0;
    SCLK1   = 1'b0;
    err_exp = 1'b0;
    tick();
    chk("mid_rst_cen", 32'(CEN), 32'd1);
    chk("mid_rst_po", 32'(PO), 32'd0);
    chk("mid_rst_a", 32'(A), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_rst_nowrite", 32'(wr_log.size() - idx0), 32'd0);
    chk("mid_rst_waits", 32'(spi_is_done), 32'd0);
    tx[0] = 8'h81;
    push_writes(9'h0AA, 1);
    start(9'h0AA, 8'd1);
    send_byte(tx[0], -1);
    wait_done("post_rst_xfer_done", 4);
    chk("post_rst_xfer", 32'(wr_log[wr_log.size() - 1]), 32'({9'h0AB, 8'h81}));
    finish_xfer();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
